// File: rtl/mmr_intr_status_bank_if.sv
// rtl/mmr_intr_status_bank_if.sv - MMR/interrupt bundle between the status bank and its user
//
// Purpose : carries event pulses, the single-cycle MMR read/write port and the
//           interrupt request.
// Params  : N - number of 32-bit ISR/IMR word pairs.
// Modports: master - the status bank: drives isr, imr, rd_data, rd_valid, irq.
//           slave  - the user side: drives isr_pulses and the MMR strobes.
interface mmr_intr_status_bank_if #(
   parameter int N = 1
);
   localparam int AW = $clog2(2 * N + 1);

   logic [N-1:0][31:0] isr_pulses;
   logic [N-1:0][31:0] isr;
   logic [N-1:0][31:0] imr;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [31:0]        wr_data;
   logic               rd_en;
   logic [AW-1:0]      rd_addr;
   logic [31:0]        rd_data;
   logic               rd_valid;
   logic               irq;

   modport master (
      input  isr_pulses, wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output isr, imr, rd_data, rd_valid, irq
   );

   modport slave (
      output isr_pulses, wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  isr, imr, rd_data, rd_valid, irq
   );
endinterface

// File: rtl/mmr_intr_status_bank.sv
// rtl/mmr_intr_status_bank.sv - sticky interrupt status/mask bank with registered irq
//
// Purpose : accumulates per-source event pulses into sticky W1C ISR words,
//           holds RW IMR words (1 = masked) and raises one registered level irq
//           when any unmasked ISR bit is set.
// Address : 2i = ISR[i] (W1C), 2i+1 = IMR[i] (RW), 2N = HOLDOFF (RW) or reserved.
// Options : MMR_INTR_HOLDOFF_EN - adds the HOLDOFF register and a holdoff FSM
//           that keeps irq low for HOLDOFF cycles after each serviced interrupt.
// Ports   : clock - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - mmr_intr_status_bank_if.master (pulses, MMR port, isr/imr, irq)
module mmr_intr_status_bank #(
   parameter int N         = 1,
   parameter int HOLDOFF_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   mmr_intr_status_bank_if.master bus
);
   localparam int AW = $clog2(2 * N + 1);

   logic [N-1:0][31:0]   isr_q, isr_d;
   logic [N-1:0][31:0]   imr_q, imr_d;
   logic [31:0]          rd_data_q, rd_data_d;
   logic                 rd_valid_q;
   logic                 irq_q, irq_d;
   logic                 pending;
   logic [HOLDOFF_W-1:0] holdoff_val;

   // Set wins over clear: the pulse is ORed in after the W1C mask.
   always_comb begin
      isr_d = isr_q;
      imr_d = imr_q;
      for (int i = 0; i < N; i++) begin
         isr_d[i] = (isr_q[i] & ~((bus.wr_en && bus.wr_addr == AW'(2 * i)) ? bus.wr_data : 32'h0))
                    | bus.isr_pulses[i];
         if (bus.wr_en && bus.wr_addr == AW'(2 * i + 1))
            imr_d[i] = bus.wr_data;
      end
   end

   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < N; i++)
         pending = pending | (|(isr_q[i] & ~imr_q[i]));
   end

   // Reads sample the registered state, so a same-cycle write is not yet visible.
   always_comb begin
      rd_data_d = rd_data_q;
      if (bus.rd_en) begin
         rd_data_d = 32'h0;
         for (int i = 0; i < N; i++) begin
            if (bus.rd_addr == AW'(2 * i))
               rd_data_d = isr_q[i];
            if (bus.rd_addr == AW'(2 * i + 1))
               rd_data_d = imr_q[i];
         end
         if (bus.rd_addr == AW'(2 * N))
            rd_data_d = 32'(holdoff_val);
      end
   end

`ifdef MMR_INTR_HOLDOFF_EN
   typedef enum logic {
      S_IDLE,
      S_HOLD
   } state_t;

   state_t               state_q, state_d;
   logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
   logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      irq_d     = pending;
      holdoff_d = holdoff_q;
      if (bus.wr_en && bus.wr_addr == AW'(2 * N))
         holdoff_d = bus.wr_data[HOLDOFF_W-1:0];
      case (state_q)
         S_IDLE: begin
            irq_d = pending;
            // irq currently high and about to drop: the ISR has been serviced.
            if (irq_q && !pending && holdoff_q != '0) begin
               cnt_d   = holdoff_q;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            irq_d = 1'b0;
            if (cnt_q <= HOLDOFF_W'(1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         holdoff_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         holdoff_q <= holdoff_d;
      end
   end

   assign holdoff_val = holdoff_q;
`else
   always_comb begin
      irq_d = pending;
   end

   // No HOLDOFF register: address 2N is reserved and reads back as zero.
   assign holdoff_val = '0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         isr_q      <= '0;
         imr_q      <= '1;
         rd_data_q  <= 32'h0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         isr_q      <= isr_d;
         imr_q      <= imr_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= bus.rd_en;
         irq_q      <= irq_d;
      end
   end

   assign bus.isr      = isr_q;
   assign bus.imr      = imr_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.irq      = irq_q;
endmodule

// File: tb/tb_mmr_intr_status_bank.sv
// tb/tb_mmr_intr_status_bank.sv - scoreboard bench for mmr_intr_status_bank (N = 2)
module tb_mmr_intr_status_bank;
   localparam int K_IRQ = 1;
   localparam int K_ISR = 2;
   localparam int K_IMR = 3;
   localparam int K_RDV = 4;
   localparam int K_RDD = 5;

   typedef struct {
      int          cyc;
      int          kind;
      int          idx;
      logic [31:0] val;
      string       name;
   } obs_t;

   typedef struct {
      logic [31:0] val;
      string       name;
   } rd_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   nvec  = 0;
   int   nmis  = 0;
   int   t;
   obs_t obs_q[$];
   rd_t  rd_q[$];

   mmr_intr_status_bank_if #(.N(2)) bus ();

   mmr_intr_status_bank #(.N(2), .HOLDOFF_W(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got cycle %0d required end of stimulus", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      nvec++;
      if (act !== exp_v) begin
         nmis++;
         $display("FAIL %s @cyc %0d: got %h required %h", nm, cyc, act, exp_v);
      end
   endtask

   function automatic logic [31:0] sample(input int kind, input int idx);
      case (kind)
         K_IRQ:   return {31'h0, bus.irq};
         K_ISR:   return bus.isr[idx[0]];
         K_IMR:   return bus.imr[idx[0]];
         K_RDV:   return {31'h0, bus.rd_valid};
         default: return bus.rd_data;
      endcase
   endfunction

   function automatic void exp_obs(input int at, input int kind, input int idx,
                                   input logic [31:0] v, input string nm);
      obs_t e;
      e.cyc  = at;
      e.kind = kind;
      e.idx  = idx;
      e.val  = v;
      e.name = nm;
      obs_q.push_back(e);
   endfunction

   // Monitor: read data is popped whenever rd_valid is seen; state observations
   // are compared in the cycle they were scheduled for.
   always @(negedge clock) begin
      if (bus.rd_valid) begin
         if (rd_q.size() == 0) begin
            check("unexpected_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
         end else begin
            rd_t r;
            r = rd_q.pop_front();
            check(r.name, bus.rd_data, r.val);
         end
      end
      for (int k = obs_q.size() - 1; k >= 0; k--) begin
         if (obs_q[k].cyc == cyc) begin
            check(obs_q[k].name, sample(obs_q[k].kind, obs_q[k].idx), obs_q[k].val);
            obs_q.delete(k);
         end
      end
   end

   task automatic apply(input logic [31:0] p0, input logic [31:0] p1,
                        input logic we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic re, input logic [2:0] ra);
      bus.isr_pulses[0] = p0;
      bus.isr_pulses[1] = p1;
      bus.wr_en         = we;
      bus.wr_addr       = wa;
      bus.wr_data       = wd;
      bus.rd_en         = re;
      bus.rd_addr       = ra;
      @(posedge clock);
      #1;
      bus.isr_pulses = '0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply('0, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      apply('0, '0, 1'b1, a, d, 1'b0, 3'd0);
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] v, input string nm);
      rd_t r;
      r.val  = v;
      r.name = nm;
      rd_q.push_back(r);
      apply('0, '0, 1'b0, 3'd0, 32'h0, 1'b1, a);
   endtask

   initial begin
      bus.isr_pulses = '0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state
      t = cyc;
      exp_obs(t, K_IMR, 0, 32'hFFFF_FFFF, "rst_imr0");
      exp_obs(t, K_IMR, 1, 32'hFFFF_FFFF, "rst_imr1");
      exp_obs(t, K_ISR, 0, 32'h0, "rst_isr0");
      exp_obs(t, K_ISR, 1, 32'h0, "rst_isr1");
      exp_obs(t, K_IRQ, 0, 32'h0, "rst_irq");
      exp_obs(t, K_RDV, 0, 32'h0, "rst_rd_valid");
      exp_obs(t, K_RDD, 0, 32'h0, "rst_rd_data");
      idle(1);

      // Masked pulse on bit 3: ISR sets, irq stays low
      t = cyc;
      exp_obs(t + 1, K_ISR, 0, 32'h8, "masked_isr0");
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "masked_irq");
      apply(32'h8, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(2);

      // Clear, unmask bit 3, pulse, then W1C
      t = cyc;
      exp_obs(t + 1, K_ISR, 0, 32'h0, "w1c_isr0");
      wr(3'd0, 32'h8);
      t = cyc;
      exp_obs(t + 1, K_IMR, 0, 32'hFFFF_FFF7, "unmask_imr0");
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "unmask_idle_irq");
      wr(3'd1, 32'hFFFF_FFF7);
      t = cyc;
      exp_obs(t + 1, K_ISR, 0, 32'h8, "pulse3_isr0");
      exp_obs(t + 1, K_IRQ, 0, 32'h0, "pulse3_irq_t1");
      exp_obs(t + 2, K_IRQ, 0, 32'h1, "pulse3_irq_t2");
      apply(32'h8, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(3);
      t = cyc;
      exp_obs(t + 1, K_ISR, 0, 32'h0, "clr3_isr0");
      exp_obs(t + 1, K_IRQ, 0, 32'h1, "clr3_irq_t1");
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "clr3_irq_t2");
      wr(3'd0, 32'h8);
      idle(2);

      // Set wins, bit masked
      t = cyc;
      exp_obs(t + 1, K_ISR, 0, 32'h20, "setwin_masked_isr0");
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "setwin_masked_irq");
      apply(32'h20, '0, 1'b1, 3'd0, 32'h20, 1'b0, 3'd0);
      idle(1);
      t = cyc;
      exp_obs(t + 2, K_IRQ, 0, 32'h1, "unmask5_irq");
      wr(3'd1, 32'hFFFF_FFD7);
      idle(2);
      // Set wins while irq is asserted: irq must not glitch
      t = cyc;
      exp_obs(t + 1, K_ISR, 0, 32'h20, "setwin_isr0");
      exp_obs(t + 1, K_IRQ, 0, 32'h1, "setwin_irq_t1");
      exp_obs(t + 2, K_IRQ, 0, 32'h1, "setwin_irq_t2");
      apply(32'h20, '0, 1'b1, 3'd0, 32'h20, 1'b0, 3'd0);
      idle(2);
      t = cyc;
      exp_obs(t + 1, K_ISR, 0, 32'h0, "clr5_isr0");
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "clr5_irq");
      wr(3'd0, 32'h20);
      idle(2);

      // Multi-word: word 1 bit 0
      t = cyc;
      exp_obs(t + 1, K_IMR, 1, 32'hFFFF_FFFE, "imr1");
      wr(3'd3, 32'hFFFF_FFFE);
      t = cyc;
      exp_obs(t + 1, K_ISR, 1, 32'h1, "w1_isr1");
      exp_obs(t + 1, K_IRQ, 0, 32'h0, "w1_irq_t1");
      exp_obs(t + 2, K_IRQ, 0, 32'h1, "w1_irq_t2");
      apply('0, 32'h1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(2);

      // Back-to-back reads, reserved and out-of-range addresses
      rd(3'd5, 32'h0, "rd_addr5");
      rd(3'd7, 32'h0, "rd_addr7");
`ifndef MMR_INTR_HOLDOFF_EN
      rd(3'd4, 32'h0, "rd_addr4_reserved");
`endif
      rd(3'd2, 32'h1, "rd_isr1");
      rd(3'd1, 32'hFFFF_FFD7, "rd_imr0");
      t = cyc;
      exp_obs(t + 1, K_RDV, 0, 32'h0, "rd_valid_drop");
      exp_obs(t + 2, K_RDD, 0, 32'hFFFF_FFD7, "rd_data_hold");
      idle(3);

      // Read and write the same address in one cycle: read sees the old value
      t = cyc;
      rd_q.push_back('{val: 32'hFFFF_FFFE, name: "rdwr_imr1_old"});
      exp_obs(t + 1, K_IMR, 1, 32'hFFFF_FFFF, "rdwr_imr1_new");
      exp_obs(t + 1, K_IRQ, 0, 32'h1, "rdwr_irq_t1");
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "rdwr_irq_t2");
      apply('0, '0, 1'b1, 3'd3, 32'hFFFF_FFFF, 1'b1, 3'd3);
      t = cyc;
      rd_q.push_back('{val: 32'h1, name: "rdwr_isr1_old"});
      exp_obs(t + 1, K_ISR, 1, 32'h0, "rdwr_isr1_new");
      apply('0, '0, 1'b1, 3'd2, 32'h1, 1'b1, 3'd2);

      // Out-of-range writes change nothing
      t = cyc;
      exp_obs(t + 1, K_IMR, 0, 32'hFFFF_FFD7, "oor_imr0");
      exp_obs(t + 1, K_IMR, 1, 32'hFFFF_FFFF, "oor_imr1");
      exp_obs(t + 1, K_ISR, 0, 32'h0, "oor_isr0");
      wr(3'd6, 32'h0);
`ifndef MMR_INTR_HOLDOFF_EN
      wr(3'd4, 32'h5);
      rd(3'd4, 32'h0, "rd_addr4_after_write");
`endif
      idle(2);

`ifdef MMR_INTR_HOLDOFF_EN
      // HOLDOFF = 10: irq deasserts, stays low 10 more cycles, then re-asserts
      wr(3'd4, 32'd10);
      rd(3'd4, 32'd10, "rd_holdoff");
      t = cyc;
      exp_obs(t + 2, K_IRQ, 0, 32'h1, "ho_irq_on");
      apply(32'h8, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(2);
      t = cyc;
      exp_obs(t + 1, K_IRQ, 0, 32'h1, "ho_irq_before");
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "ho_irq_drop");
      exp_obs(t + 12, K_IRQ, 0, 32'h0, "ho_irq_still_low");
      exp_obs(t + 13, K_IRQ, 0, 32'h1, "ho_irq_reassert");
      wr(3'd0, 32'h8);
      apply(32'h8, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(14);
      wr(3'd0, 32'h8);
      idle(2);
      wr(3'd4, 32'd0);
      idle(12);
      // HOLDOFF = 0: re-assertion follows pulse timing
      t = cyc;
      exp_obs(t + 2, K_IRQ, 0, 32'h1, "ho0_irq_on");
      apply(32'h8, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(2);
      t = cyc;
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "ho0_irq_drop");
      exp_obs(t + 3, K_IRQ, 0, 32'h1, "ho0_irq_reassert");
      wr(3'd0, 32'h8);
      apply(32'h8, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(2);
      wr(3'd0, 32'h8);
      idle(3);
`endif

      // Asynchronous reset while irq is high
      t = cyc;
      exp_obs(t + 2, K_IRQ, 0, 32'h1, "prerst_irq");
      apply(32'h20, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(2);
      reset = 1'b1;
      t = cyc;
      exp_obs(t, K_IRQ, 0, 32'h0, "arst_irq");
      exp_obs(t, K_ISR, 0, 32'h0, "arst_isr0");
      exp_obs(t, K_IMR, 0, 32'hFFFF_FFFF, "arst_imr0");
      exp_obs(t, K_IMR, 1, 32'hFFFF_FFFF, "arst_imr1");
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      t = cyc;
      exp_obs(t + 1, K_ISR, 0, 32'h20, "postrst_isr0");
      exp_obs(t + 2, K_IRQ, 0, 32'h0, "postrst_irq_masked");
      apply(32'h20, '0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
      idle(4);

      check("leftover_obs", obs_q.size(), 32'h0);
      check("leftover_reads", rd_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
